stopwatch_ctrl: RTL and testbench

User-facing controller for the four-digit MM:SS stopwatch counter. Takes two raw push-buttons (start/stop, lap/reset), debounces them, and sequences the counter through idle, run, pause and lap modes. Drives the counter's start/stop/clear strobes and supplies the digits for the display, live or frozen at a lap split. Sits between the board buttons and the counter core; its digit outputs feed the 7-segment driver.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_ctrl_if.sv | 34 +++
 rtl/btn_debounce.sv | 53 +++++
 rtl/stopwatch_ctrl.sv | 101 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: state encodings, BCD digit types and
// default debounce length. Also imported by the counter core.
package stopwatch_pkg;

    localparam int unsigned DigitW                = 4;
    localparam int unsigned DefaultDebounceCycles = 1000000;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } sw_state_e;

    typedef logic [DigitW-1:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } digits_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Counter/display side of the stopwatch controller: live digits in, strobes and
// display digits out. The controller is the master.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    bcd_t       sec_ones_in;
    bcd_t       sec_tens_in;
    bcd_t       min_ones_in;
    bcd_t       min_tens_in;
    logic       sw_start;
    logic       sw_stop;
    logic       sw_clear;
    bcd_t       sec_ones_out;
    bcd_t       sec_tens_out;
    bcd_t       min_ones_out;
    bcd_t       min_tens_out;
    logic       lap_active;
    logic [1:0] state;

    modport master (
        input  sec_ones_in, sec_tens_in, min_ones_in, min_tens_in,
        output sw_start, sw_stop, sw_clear,
        output sec_ones_out, sec_tens_out, min_ones_out, min_tens_out,
        output lap_active, state
    );

    modport slave (
        output sec_ones_in, sec_tens_in, min_ones_in, min_tens_in,
        input  sw_start, sw_stop, sw_clear,
        input  sec_ones_out, sec_tens_out, min_ones_out, min_tens_out,
        input  lap_active, state
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer for one raw button.
// press is a one-cycle pulse on the debounced rising edge.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned       CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0]   CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    // Any cycle where the synchronized level agrees with the accepted one restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button-driven sequencer for the MM:SS stopwatch: idle/run/pause/lap modes,
// counter strobes, and a display mux that can freeze a lap split.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_ss,
    input  logic             btn_lr,
    stopwatch_ctrl_if.master bus
);

    logic      ss_press, lr_press;
    logic      ss_ev, lr_ev;
    sw_state_e state_q, state_d;
    logic      start_q, start_d;
    logic      stop_q, stop_d;
    logic      clear_q, clear_d;
    logic      lap_capture;
    digits_t   live, lap_q, shown;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_ss (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_ss),
        .press(ss_press)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_lr (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_lr),
        .press(lr_press)
    );

    // Start/stop wins when both buttons fire together.
    assign ss_ev = ss_press;
    assign lr_ev = lr_press & ~ss_press;

    assign live = '{
        min_tens: bus.min_tens_in,
        min_ones: bus.min_ones_in,
        sec_tens: bus.sec_tens_in,
        sec_ones: bus.sec_ones_in
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
            lap_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            clear_q <= clear_d;
            if (lap_capture) begin
                lap_q <= live;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ss_ev) state_d = StRun;
            StRun:   if (ss_ev) state_d = StPause; else if (lr_ev) state_d = StLap;
            StLap:   if (ss_ev) state_d = StPause; else if (lr_ev) state_d = StRun;
            StPause: if (ss_ev) state_d = StRun;   else if (lr_ev) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        start_d     = ss_ev & ((state_q == StIdle) | (state_q == StPause));
        stop_d      = ss_ev & ((state_q == StRun) | (state_q == StLap));
        clear_d     = lr_ev & (state_q == StPause);
        lap_capture = lr_ev & (state_q == StRun);
    end

    assign shown = (state_q == StLap) ? lap_q : live;

    assign bus.sw_start     = start_q;
    assign bus.sw_stop      = stop_q;
    assign bus.sw_clear     = clear_q;
    assign bus.lap_active   = (state_q == StLap);
    assign bus.state        = state_q;
    assign bus.sec_ones_out = shown.sec_ones;
    assign bus.sec_tens_out = shown.sec_tens;
    assign bus.min_ones_out = shown.min_ones;
    assign bus.min_tens_out = shown.min_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4: directed scenarios plus a randomized
// run against a sample-window reference model of the buttons and mode rules.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_ss = 1'b0;
    logic btn_lr = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_ss(btn_ss),
        .btn_lr(btn_lr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a button level flips once the last DEB synchronizer-output samples
    // all disagree with it; the synchronizer output at edge i is the raw sample of edge i-2.
    bit        h_ss[$];
    bit        h_lr[$];
    bit        lvl_ss = 1'b0, lvl_lr = 1'b0;
    bit        rose_ss = 1'b0, rose_lr = 1'b0;
    int        m_state = 0;
    bit        m_start = 1'b0, m_stop = 1'b0, m_clear = 1'b0;
    logic [3:0] m_lap[4] = '{4'd0, 4'd0, 4'd0, 4'd0};

    function automatic bit seen(input bit h[$], input int i);
        return (i >= 2) ? h[i-2] : 1'b0;
    endfunction

    function automatic bit deb_step(input bit h[$], input bit lvl);
        int i = h.size() - 1;
        if (i < DEB - 1) return lvl;
        for (int k = i - DEB + 1; k <= i; k++) begin
            if (seen(h, k) == lvl) return lvl;
        end
        return ~lvl;
    endfunction

    task automatic model_step();
        bit ev_ss, ev_lr, old;
        if (rst) begin
            h_ss.delete();
            h_lr.delete();
            lvl_ss = 0; lvl_lr = 0; rose_ss = 0; rose_lr = 0;
            m_state = 0; m_start = 0; m_stop = 0; m_clear = 0;
            m_lap = '{4'd0, 4'd0, 4'd0, 4'd0};
        end else begin
            ev_ss = rose_ss;
            ev_lr = rose_lr && !rose_ss;
            m_start = 0; m_stop = 0; m_clear = 0;
            case (m_state)
                0: if (ev_ss) begin m_state = 1; m_start = 1; end
                1: if (ev_ss) begin m_state = 2; m_stop = 1; end
                   else if (ev_lr) begin
                       m_state = 3;
                       m_lap = '{bus.sec_ones_in, bus.sec_tens_in, bus.min_ones_in, bus.min_tens_in};
                   end
                3: if (ev_ss) begin m_state = 2; m_stop = 1; end
                   else if (ev_lr) m_state = 1;
                default: if (ev_ss) begin m_state = 1; m_start = 1; end
                   else if (ev_lr) begin m_state = 0; m_clear = 1; end
            endcase
            h_ss.push_back(btn_ss);
            old = lvl_ss; lvl_ss = deb_step(h_ss, lvl_ss); rose_ss = lvl_ss && !old;
            h_lr.push_back(btn_lr);
            old = lvl_lr; lvl_lr = deb_step(h_lr, lvl_lr); rose_lr = lvl_lr && !old;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    logic [21:0] obs_vec, exp_vec;
    assign obs_vec = {bus.state, bus.sw_start, bus.sw_stop, bus.sw_clear, bus.lap_active,
                      bus.min_tens_out, bus.min_ones_out, bus.sec_tens_out, bus.sec_ones_out};

    always_comb begin
        exp_vec = {2'(m_state), m_start, m_stop, m_clear, (m_state == 3),
                   bus.min_tens_in, bus.min_ones_in, bus.sec_tens_in, bus.sec_ones_in};
        if (m_state == 3) exp_vec[15:0] = {m_lap[3], m_lap[2], m_lap[1], m_lap[0]};
    end

    task automatic set_digits(input logic [3:0] so, st, mo, mt);
        bus.sec_ones_in = so;
        bus.sec_tens_in = st;
        bus.min_ones_in = mo;
        bus.min_tens_in = mt;
    endtask

    task automatic rand_digits();
        set_digits(4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                   4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)));
    endtask

    // Holds the requested buttons long enough for one event, releases, and tallies outputs.
    task automatic press(input bit ss, input bit lr, output int ns, output int nt,
                         output int nc, output int nl);
        ns = 0; nt = 0; nc = 0; nl = 0;
        btn_ss = ss;
        btn_lr = lr;
        for (int c = 0; c < 2 * (DEB + 6); c++) begin
            if (c == DEB + 6) begin
                btn_ss = 0;
                btn_lr = 0;
            end
            @(negedge clk);
            ns += int'(bus.sw_start);
            nt += int'(bus.sw_stop);
            nc += int'(bus.sw_clear);
            nl += int'(bus.lap_active);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        set_digits(4'd7, 4'd4, 4'd5, 4'd2);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.state, bus.sw_start, bus.sw_stop, bus.sw_clear, bus.lap_active} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got state=%b strobes=%b%b%b lap=%b want 00/000/0",
                     bus.state, bus.sw_start, bus.sw_stop, bus.sw_clear, bus.lap_active);
        end else n_pass++;
        n_checks++;
        if (obs_vec[15:0] !== 16'h2547) begin
            n_fail++;
            $display("FAIL reset_display: got %h want 2547", obs_vec[15:0]);
        end else n_pass++;
        rst = 0;
        @(negedge clk);
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", obs_vec, exp_vec);
        end else n_pass++;
    endtask

    // Raw button set before E0; the k-th following negedge is just after edge E0+k-1.
    task automatic test_start();
        int ns, nt, nc, nl;
        btn_ss = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sw_start !== (k == 7)) begin
                n_fail++;
                $display("FAIL start_timing k=%0d: got sw_start=%b want %b", k, bus.sw_start, k == 7);
            end else n_pass++;
        end
        n_checks++;
        if (bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL start_state: got %b want 01", bus.state);
        end else n_pass++;
        btn_ss = 0;
        repeat (DEB + 6) @(negedge clk);
        btn_ss = 1;
        repeat (3) @(negedge clk);
        btn_ss = 0;
        ns = 0; nt = 0; nc = 0; nl = 0;
        repeat (12) begin
            @(negedge clk);
            ns += int'(bus.sw_start); nt += int'(bus.sw_stop); nc += int'(bus.sw_clear);
        end
        n_checks++;
        if (ns + nt + nc != 0 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL glitch: got strobes=%0d state=%b want 0 01", ns + nt + nc, bus.state);
        end else n_pass++;
    endtask

    task automatic test_lap();
        int ns, nt, nc, nl;
        set_digits(4'd1, 4'd2, 4'd3, 4'd0);
        btn_lr = 1;
        repeat (7) @(negedge clk);
        n_checks++;
        if (bus.state !== 2'b11 || bus.lap_active !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_enter: got state=%b lap=%b want 11 1", bus.state, bus.lap_active);
        end else n_pass++;
        for (int c = 0; c < 5; c++) begin
            rand_digits();
            #1;
            n_checks++;
            if (obs_vec[15:0] !== 16'h0321) begin
                n_fail++;
                $display("FAIL lap_hold c=%0d: got %h want 0321", c, obs_vec[15:0]);
            end else n_pass++;
            @(negedge clk);
        end
        btn_lr = 0;
        repeat (DEB + 6) @(negedge clk);
        press(0, 1, ns, nt, nc, nl);
        set_digits(4'd9, 4'd5, 4'd8, 4'd4);
        #1;
        n_checks++;
        if (bus.state !== 2'b01 || ns + nt + nc != 0 || obs_vec[15:0] !== 16'h4859) begin
            n_fail++;
            $display("FAIL lap_exit: got state=%b strobes=%0d disp=%h want 01 0 4859",
                     bus.state, ns + nt + nc, obs_vec[15:0]);
        end else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_pause_clear();
        int ns, nt, nc, nl;
        press(1, 0, ns, nt, nc, nl);
        n_checks++;
        if (bus.state !== 2'b10 || ns != 0 || nt != 1 || nc != 0) begin
            n_fail++;
            $display("FAIL pause: got state=%b start/stop/clear=%0d/%0d/%0d want 10 0/1/0",
                     bus.state, ns, nt, nc);
        end else n_pass++;
        press(0, 1, ns, nt, nc, nl);
        n_checks++;
        if (bus.state !== 2'b00 || ns != 0 || nt != 0 || nc != 1) begin
            n_fail++;
            $display("FAIL clear: got state=%b start/stop/clear=%0d/%0d/%0d want 00 0/0/1",
                     bus.state, ns, nt, nc);
        end else n_pass++;
        press(0, 1, ns, nt, nc, nl);
        n_checks++;
        if (bus.state !== 2'b00 || ns + nt + nc != 0) begin
            n_fail++;
            $display("FAIL idle_lr: got state=%b strobes=%0d want 00 0", bus.state, ns + nt + nc);
        end else n_pass++;
    endtask

    task automatic test_simultaneous();
        int ns, nt, nc, nl;
        press(1, 0, ns, nt, nc, nl);
        press(1, 1, ns, nt, nc, nl);
        n_checks++;
        if (bus.state !== 2'b10 || ns != 0 || nt != 1 || nc != 0 || nl != 0) begin
            n_fail++;
            $display("FAIL simultaneous: got state=%b s/p/c/lap=%0d/%0d/%0d/%0d want 10 0/1/0/0",
                     bus.state, ns, nt, nc, nl);
        end else n_pass++;
        n_checks++;
        if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL simultaneous_model: got %h want %h", obs_vec, exp_vec);
        end else n_pass++;
    endtask

    task automatic test_held_reset();
        int ns;
        rst = 1;
        btn_ss = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sw_start !== (k == 7)) begin
                n_fail++;
                $display("FAIL held_reset k=%0d: got sw_start=%b want %b", k, bus.sw_start, k == 7);
            end else n_pass++;
        end
        btn_ss = 0;
        ns = 0;
        repeat (12) begin
            @(negedge clk);
            ns += int'(bus.sw_start) + int'(bus.sw_stop) + int'(bus.sw_clear);
        end
        n_checks++;
        if (ns != 0 || bus.state !== 2'b01) begin
            n_fail++;
            $display("FAIL release: got strobes=%0d state=%b want 0 01", ns, bus.state);
        end else n_pass++;
    endtask

    task automatic test_random();
        int hold_ss = 0, hold_lr = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random c=%0d: got %h want %h", c, obs_vec, exp_vec);
            end else n_pass++;
            rst = ($urandom_range(0, 299) == 0);
            if (hold_ss == 0) begin
                btn_ss = 1'($urandom_range(0, 1));
                hold_ss = $urandom_range(1, 9);
            end
            hold_ss--;
            if (hold_lr == 0) begin
                btn_lr = 1'($urandom_range(0, 1));
                hold_lr = $urandom_range(1, 9);
            end
            hold_lr--;
            rand_digits();
        end
    endtask

    initial begin
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_start();
        test_lap();
        test_pause_clear();
        test_simultaneous();
        test_held_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
